// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection controller slice: lamp codes,
// fault codes, monitor state encoding and small code-classification helpers.
package traffic_pkg;

  localparam logic [2:0] GREEN  = 3'b001;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] DARK   = 3'b000;

  localparam logic [2:0] FC_NONE      = 3'd0;
  localparam logic [2:0] FC_ILLEGAL   = 3'd1;
  localparam logic [2:0] FC_CONFLICT  = 3'd2;
  localparam logic [2:0] FC_SKIP      = 3'd3;
  localparam logic [2:0] FC_SHORT_YEL = 3'd4;

  typedef enum logic [1:0] {
    MON       = 2'd0,
    FLASH_ON  = 2'd1,
    FLASH_OFF = 2'd2
  } mon_state_t;

  function automatic logic is_legal(input logic [2:0] code);
    return (code == GREEN) || (code == YELLOW) || (code == RED);
  endfunction

  function automatic logic is_active(input logic [2:0] code);
    return (code == GREEN) || (code == YELLOW);
  endfunction

endpackage

// File: rtl/head_transition_checker.sv
// Per-head sequence checker: remembers the last sampled code and how long the
// head has been yellow, and flags green->red skips and too-short yellows.
module head_transition_checker
  import traffic_pkg::*;
#(
  parameter int MIN_YELLOW = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] code,
  input  logic       sync,
  output logic       skip,
  output logic       short_yel
);

  localparam int YW = $clog2(MIN_YELLOW + 1);

  logic [2:0]    prev;
  logic [YW-1:0] ycnt;

  assign skip      = (prev == GREEN) && (code == RED);
  assign short_yel = (prev == YELLOW) && (code == RED) && (ycnt < YW'(MIN_YELLOW));

  // ycnt saturates at MIN_YELLOW so a long yellow never wraps back below the limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= RED;
      ycnt <= '0;
    end else begin
      prev <= code;
      if (sync || (code != YELLOW))
        ycnt <= '0;
      else if (ycnt != YW'(MIN_YELLOW))
        ycnt <= ycnt + YW'(1);
    end
  end

endmodule

// File: rtl/signal_conflict_monitor.sv
// Fail-safe monitor between the phase controller and the lamp drivers: passes
// head codes through, and latches an all-red flashing fault on unsafe input.
module signal_conflict_monitor
  import traffic_pkg::*;
#(
  parameter int PERSIST    = 2,
  parameter int MIN_YELLOW = 2,
  parameter int FLASH_HALF = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] m1,
  input  logic [2:0] m2,
  input  logic [2:0] m3,
  input  logic [2:0] m4,
  input  logic       clear,
  output logic [2:0] lamp1,
  output logic [2:0] lamp2,
  output logic [2:0] lamp3,
  output logic [2:0] lamp4,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam int PW = $clog2(PERSIST + 1);
  localparam int FW = $clog2(FLASH_HALF + 1);

  logic [2:0]    m    [4];
  logic [2:0]    lamp [4];
  logic [3:0]    act;
  logic [3:0]    skip;
  logic [3:0]    short_yel;
  logic          illegal;
  logic          conflict;
  logic          level_viol;
  logic          trans_fault;
  logic          sync;
  logic [2:0]    code_next;
  mon_state_t    state;
  logic [PW-1:0] pcnt;
  logic [FW-1:0] fcnt;

  assign m[0]  = m1;
  assign m[1]  = m2;
  assign m[2]  = m3;
  assign m[3]  = m4;
  assign lamp1 = lamp[0];
  assign lamp2 = lamp[1];
  assign lamp3 = lamp[2];
  assign lamp4 = lamp[3];

  assign illegal = !is_legal(m1) || !is_legal(m2) || !is_legal(m3) || !is_legal(m4);
  assign act     = {is_active(m4), is_active(m3), is_active(m2), is_active(m1)};
  // m1 may share green with m2 or m4; every other active pairing is unsafe
  assign conflict    = (act[2] && (act[0] || act[1] || act[3])) || (act[1] && act[3]);
  assign level_viol  = illegal || conflict;
  assign trans_fault = (|skip) || (|short_yel);
  assign sync        = (state != MON) && clear && !level_viol;

  for (genvar i = 0; i < 4; i++) begin : g_head
    head_transition_checker #(
      .MIN_YELLOW(MIN_YELLOW)
    ) u_chk (
      .clk      (clk),
      .rst      (rst),
      .code     (m[i]),
      .sync     (sync),
      .skip     (skip[i]),
      .short_yel(short_yel[i])
    );
  end

  always_comb begin
    code_next = FC_SHORT_YEL;
    if (illegal)
      code_next = FC_ILLEGAL;
    else if (conflict)
      code_next = FC_CONFLICT;
    else if (|skip)
      code_next = FC_SKIP;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= MON;
      pcnt       <= '0;
      fcnt       <= '0;
      fault      <= 1'b0;
      fault_code <= FC_NONE;
      for (int i = 0; i < 4; i++) lamp[i] <= RED;
    end else begin
      case (state)
        MON: begin
          if (trans_fault || (level_viol && (pcnt == PW'(PERSIST - 1)))) begin
            state      <= FLASH_ON;
            fault      <= 1'b1;
            fault_code <= code_next;
            pcnt       <= '0;
            fcnt       <= '0;
            for (int i = 0; i < 4; i++) lamp[i] <= RED;
          end else if (level_viol) begin
            pcnt <= pcnt + PW'(1);
          end else begin
            pcnt <= '0;
            for (int i = 0; i < 4; i++) lamp[i] <= m[i];
          end
        end
        default: begin
          if (sync) begin
            state      <= MON;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
            pcnt       <= '0;
            fcnt       <= '0;
            for (int i = 0; i < 4; i++) lamp[i] <= m[i];
          end else if (fcnt == FW'(FLASH_HALF - 1)) begin
            fcnt <= '0;
            if (state == FLASH_ON) begin
              state <= FLASH_OFF;
              for (int i = 0; i < 4; i++) lamp[i] <= DARK;
            end else begin
              state <= FLASH_ON;
              for (int i = 0; i < 4; i++) lamp[i] <= RED;
            end
          end else begin
            fcnt <= fcnt + FW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signal_conflict_monitor.sv
// Self-checking bench for signal_conflict_monitor: directed scenarios plus
// randomized head sequences compared each cycle against a behavioural model.
module tb_signal_conflict_monitor;

  localparam int PERSIST    = 2;
  localparam int MIN_YELLOW = 2;
  localparam int FLASH_HALF = 4;

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] D = 3'b000;

  logic       clk;
  logic       rst;
  logic [2:0] m1, m2, m3, m4;
  logic       clear;
  logic [2:0] lamp1, lamp2, lamp3, lamp4;
  logic       fault;
  logic [2:0] fault_code;

  int n_pass;
  int n_total;

  // behavioural model state
  logic [2:0] exp_lamp [4];
  logic       exp_fault;
  logic [2:0] exp_code;
  bit         flashing;
  int         age;
  int         streak;
  logic [2:0] prevc [4];
  int         yrun [4];

  signal_conflict_monitor #(
    .PERSIST   (PERSIST),
    .MIN_YELLOW(MIN_YELLOW),
    .FLASH_HALF(FLASH_HALF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m1        (m1),
    .m2        (m2),
    .m3        (m3),
    .m4        (m4),
    .clear     (clear),
    .lamp1     (lamp1),
    .lamp2     (lamp2),
    .lamp3     (lamp3),
    .lamp4     (lamp4),
    .fault     (fault),
    .fault_code(fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
  endtask

  function automatic bit isActive(input logic [2:0] c);
    return (c == G) || (c == Y);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 4; i++) begin
      exp_lamp[i] = R;
      prevc[i]    = R;
      yrun[i]     = 0;
    end
    exp_fault = 1'b0;
    exp_code  = 3'd0;
    flashing  = 0;
    age       = 0;
    streak    = 0;
  endtask

  // what the outputs must become after one sampled edge with the current inputs
  task automatic modelStep();
    logic [2:0] c [4];
    bit ill, conf, lv, sk, sy, honoured;
    c[0] = m1; c[1] = m2; c[2] = m3; c[3] = m4;
    ill = 0; sk = 0; sy = 0; honoured = 0;
    for (int i = 0; i < 4; i++) begin
      if (!(c[i] == G || c[i] == Y || c[i] == R)) ill = 1;
      if (prevc[i] == G && c[i] == R) sk = 1;
      if (prevc[i] == Y && c[i] == R && yrun[i] < MIN_YELLOW) sy = 1;
    end
    conf = (isActive(c[2]) && (isActive(c[0]) || isActive(c[1]) || isActive(c[3])))
           || (isActive(c[1]) && isActive(c[3]));
    lv = ill || conf;
    if (!flashing) begin
      streak = lv ? streak + 1 : 0;
      if (sk || sy || streak >= PERSIST) begin
        flashing = 1;
        age      = 0;
        streak   = 0;
        exp_code = ill ? 3'd1 : conf ? 3'd2 : sk ? 3'd3 : 3'd4;
      end else if (!lv) begin
        for (int i = 0; i < 4; i++) exp_lamp[i] = c[i];
      end
    end else if (clear && !lv) begin
      flashing = 0;
      exp_code = 3'd0;
      streak   = 0;
      honoured = 1;
      for (int i = 0; i < 4; i++) exp_lamp[i] = c[i];
    end else begin
      age++;
    end
    if (flashing)
      for (int i = 0; i < 4; i++) exp_lamp[i] = ((age / FLASH_HALF) % 2 == 0) ? R : D;
    exp_fault = flashing;
    for (int i = 0; i < 4; i++) begin
      yrun[i]  = honoured ? 0 : ((c[i] == Y) ? yrun[i] + 1 : 0);
      prevc[i] = c[i];
    end
  endtask

  task automatic applyStimulus(input logic [2:0] a, input logic [2:0] b,
                               input logic [2:0] c, input logic [2:0] d, input logic clr);
    m1 = a; m2 = b; m3 = c; m4 = d; clear = clr;
    @(posedge clk);
    modelStep();
    #1;
  endtask

  always @(negedge clk) begin
    checkOutput("lamp1", lamp1, exp_lamp[0]);
    checkOutput("lamp2", lamp2, exp_lamp[1]);
    checkOutput("lamp3", lamp3, exp_lamp[2]);
    checkOutput("lamp4", lamp4, exp_lamp[3]);
    checkOutput("fault", {2'b00, fault}, {2'b00, exp_fault});
    checkOutput("fault_code", fault_code, exp_code);
  end

  initial begin
    logic [2:0] cur [4];
    int r;
    int h;
    n_pass = 0;
    n_total = 0;
    m1 = R; m2 = R; m3 = R; m4 = R; clear = 1'b0;
    rst = 1'b1;
    modelReset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    checkOutput("reset_lamp1", lamp1, 3'b100);
    checkOutput("reset_fault", {2'b00, fault}, 3'd0);
    checkOutput("reset_code", fault_code, 3'd0);

    // legal sequence with a full yellow on m4
    applyStimulus(G, R, R, G, 0);
    checkOutput("pass_lamp4", lamp4, 3'b001);
    applyStimulus(G, R, R, Y, 0);
    applyStimulus(G, R, R, Y, 0);
    applyStimulus(G, R, R, R, 0);
    checkOutput("legal_fault", {2'b00, fault}, 3'd0);

    // illegal code held for PERSIST cycles
    applyStimulus(G, R, 3'b101, R, 0);
    checkOutput("illegal_hold_lamp1", lamp1, 3'b001);
    applyStimulus(G, R, 3'b101, R, 0);
    checkOutput("illegal_code", fault_code, 3'd1);
    checkOutput("illegal_lamp1", lamp1, 3'b100);
    repeat (3) applyStimulus(G, R, 3'b101, R, 0);
    checkOutput("flash_on_last", lamp2, 3'b100);
    applyStimulus(G, R, 3'b101, R, 0);
    checkOutput("flash_off_lamp1", lamp1, 3'b000);
    applyStimulus(G, R, 3'b101, R, 1);
    checkOutput("clear_ignored", {2'b00, fault}, 3'd1);
    applyStimulus(R, R, R, R, 1);
    checkOutput("clear_code", fault_code, 3'd0);
    checkOutput("clear_lamp1", lamp1, 3'b100);

    // one-cycle violation leaves no fault
    applyStimulus(R, R, 3'b101, R, 0);
    checkOutput("glitch_fault", {2'b00, fault}, 3'd0);
    applyStimulus(R, R, G, R, 0);
    checkOutput("glitch_resume", lamp3, 3'b001);
    applyStimulus(R, R, Y, R, 0);
    applyStimulus(R, R, Y, R, 0);
    applyStimulus(R, R, R, R, 0);

    // persistent conflict m2+m4
    applyStimulus(R, G, R, G, 0);
    applyStimulus(R, G, R, G, 0);
    checkOutput("conflict_code", fault_code, 3'd2);
    applyStimulus(R, R, R, R, 1);

    // green straight to red
    applyStimulus(G, R, R, R, 0);
    applyStimulus(R, R, R, R, 0);
    checkOutput("skip_code", fault_code, 3'd3);
    applyStimulus(R, R, R, R, 1);

    // one-cycle yellow
    applyStimulus(R, R, R, G, 0);
    applyStimulus(R, R, R, Y, 0);
    applyStimulus(R, R, R, R, 0);
    checkOutput("short_yel_code", fault_code, 3'd4);
    repeat (4) applyStimulus(R, R, R, R, 0);
    checkOutput("dark_before_rst", lamp4, 3'b000);

    // asynchronous reset mid-flash
    #2 rst = 1'b1;
    modelReset();
    #1;
    checkOutput("rst_lamp4", lamp4, 3'b100);
    checkOutput("rst_fault", {2'b00, fault}, 3'd0);
    checkOutput("rst_code", fault_code, 3'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // randomized head sequences
    for (int i = 0; i < 4; i++) cur[i] = R;
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(99);
      h = $urandom_range(3);
      if (r < 10) begin
        for (int i = 0; i < 4; i++) cur[i] = R;
      end else if (r < 15) begin
        cur[h] = 3'($urandom_range(7));
      end else if (r < 70) begin
        case (cur[h])
          G:       cur[h] = Y;
          Y:       cur[h] = ($urandom_range(1) == 0) ? Y : R;
          R:       cur[h] = G;
          default: cur[h] = R;
        endcase
      end else if (r < 75) begin
        case ($urandom_range(2))
          0:       cur[h] = G;
          1:       cur[h] = Y;
          default: cur[h] = R;
        endcase
      end
      applyStimulus(cur[0], cur[1], cur[2], cur[3], ($urandom_range(3) == 0));
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
